// File: rtl/life_pkg.sv
// Shared types and sizing helpers for the Life array readback path.
// Counter widths are clamped to at least one bit.
package life_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int words_per_row(input int cols, input int ww);
      return (cols + ww - 1) / ww;
   endfunction

endpackage

// File: rtl/life_word_select.sv
// Picks one zero-padded output word of a row out of the snapshot.
// Column 0 of the slice lands in bit 0.
module life_word_select
   import life_pkg::*;
#(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int WORD_W = 8,
   parameter int RW     = 3,
   parameter int WW     = 1
) (
   input  logic [ROWS*COLS-1:0] snap,
   input  logic [RW-1:0]        row,
   input  logic [WW-1:0]        word,
   output logic [WORD_W-1:0]    data
);

   // gather the cells of one word, padding past the last column with 0
   always_comb begin
      int col;
      int base;
      data = '0;
      base = int'(row) * COLS;
      for (int i = 0; i < WORD_W; i++) begin
         col = int'(word) * WORD_W + i;
         if (col < COLS && int'(row) < ROWS) begin
            data[i] = snap[base + col];
         end
      end
   end

endmodule

// File: rtl/life_array_reader.sv
// Snapshots one generation of the cell array and streams it out
// row by row as fixed-width words over a valid/ready port.
module life_array_reader
   import life_pkg::*;
#(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int WORD_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     sel_prev,
   input  logic [ROWS*COLS-1:0]     alive_flat,
   input  logic [ROWS*COLS-1:0]     alive_prev_flat,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [WORD_W-1:0]        out_data,
   output logic [cnt_w(ROWS)-1:0]   out_row,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   localparam int WPR = words_per_row(COLS, WORD_W);
   localparam int RW  = cnt_w(ROWS);
   localparam int WW  = cnt_w(WPR);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(WPR - 1);

   state_t                 state, state_n;
   logic [RW-1:0]          row_q, row_n;
   logic [WW-1:0]          word_q, word_n;
   logic [ROWS*COLS-1:0]   snap_q, snap_n;
   logic [ROWS*COLS-1:0]   src;
   logic [WORD_W-1:0]      sel_data;
   logic                   valid_n, last_n, busy_n, done_n;
   logic [WORD_W-1:0]      data_n;

   // the word for the next cycle comes from the live plane on the start edge
   assign src = (state == IDLE) ? (sel_prev ? alive_prev_flat : alive_flat)
                                : snap_q;

   life_word_select #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .WORD_W (WORD_W),
      .RW     (RW),
      .WW     (WW)
   ) u_sel (
      .snap (src),
      .row  (row_n),
      .word (word_n),
      .data (sel_data)
   );

   // next-state, counter advance and next registered outputs
   always_comb begin
      state_n = state;
      row_n   = row_q;
      word_n  = word_q;
      snap_n  = snap_q;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               snap_n  = src;
               row_n   = '0;
               word_n  = '0;
               valid_n = 1'b1;
               busy_n  = 1'b1;
               state_n = SEND;
            end
         end
         SEND: begin
            valid_n = 1'b1;
            busy_n  = 1'b1;
            if (out_ready) begin
               if (row_q == ROW_LAST && word_q == WORD_LAST) begin
                  valid_n = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = DONE;
               end else if (word_q == WORD_LAST) begin
                  word_n = '0;
                  row_n  = row_q + RW'(1);
               end else begin
                  word_n = word_q + WW'(1);
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      last_n = valid_n && row_n == ROW_LAST && word_n == WORD_LAST;
      data_n = valid_n ? sel_data : out_data;
   end

   // state, counters, snapshot and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         row_q     <= '0;
         word_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         row_q     <= row_n;
         word_q    <= word_n;
         out_valid <= valid_n;
         out_data  <= data_n;
         out_row   <= row_n;
         out_last  <= last_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   // snapshot holds its contents across reset
   always_ff @(posedge clk) begin
      snap_q <= snap_n;
   end

endmodule

// File: tb/tb_life_array_reader.sv
// Directed bench for life_array_reader at ROWS=4, COLS=12, WORD_W=8.
// Frames are collected from the stream and compared word by word.
module tb_life_array_reader;

   localparam int ROWS   = 4;
   localparam int COLS   = 12;
   localparam int WORD_W = 8;
   localparam int NW     = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic                  sel_prev;
   logic [ROWS*COLS-1:0]  alive_flat;
   logic [ROWS*COLS-1:0]  alive_prev_flat;
   logic                  out_ready;
   logic                  out_valid;
   logic [WORD_W-1:0]     out_data;
   logic [1:0]            out_row;
   logic                  out_last;
   logic                  busy;
   logic                  done;

   int checks = 0;
   int errors = 0;

   logic [7:0] q_data[$];
   logic [1:0] q_row[$];
   logic       q_last[$];
   int         n_done;
   int         done_cyc;

   always #5 clk = ~clk;

   life_array_reader #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .WORD_W (WORD_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .sel_prev        (sel_prev),
      .alive_flat      (alive_flat),
      .alive_prev_flat (alive_prev_flat),
      .out_ready       (out_ready),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_row         (out_row),
      .out_last        (out_last),
      .busy            (busy),
      .done            (done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] pattern_plane();
      logic [47:0] p;
      for (int r = 0; r < ROWS; r++) p[r*12 +: 12] = 12'hA5C ^ 12'(r);
      return p;
   endfunction

   function automatic logic [7:0] exp_word(input logic [47:0] p,
                                           input int r, input int w);
      logic [7:0] d;
      d = '0;
      for (int i = 0; i < 8; i++)
         if (w*8 + i < COLS) d[i] = p[r*COLS + w*8 + i];
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready high; mode 1: ready 1,0,0,1 repeating
   task automatic run_frame(input bit sp, input int mode,
                            input bit scramble, input bit poke);
      logic [7:0] hd;
      logic [1:0] hr;
      logic       hl;
      bit         stalled;
      int         cyc;
      bit         seen;
      int         post;
      q_data.delete();
      q_row.delete();
      q_last.delete();
      n_done = 0;
      done_cyc = -1;
      stalled = 0;
      seen = 0;
      post = 0;
      sel_prev = sp;
      start = 1'b1;
      tick();
      start = 1'b0;
      sel_prev = ~sp;
      check("first_valid", out_valid, 1);
      check("first_busy", busy, 1);
      check("first_row", out_row, 0);
      cyc = 0;
      while (cyc < 200 && post < 3) begin
         if (mode == 0) out_ready = 1'b1;
         else out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (out_valid) begin
            if (stalled) begin
               check("stall_data", out_data, hd);
               check("stall_row", out_row, hr);
               check("stall_last", out_last, hl);
            end
            if (out_ready) begin
               q_data.push_back(out_data);
               q_row.push_back(out_row);
               q_last.push_back(out_last);
            end
            stalled = !out_ready;
            hd = out_data;
            hr = out_row;
            hl = out_last;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
            seen = 1;
         end
         if (seen && !done) begin
            check("post_valid", out_valid, 0);
            post++;
         end
         if (scramble) alive_flat = {$urandom, $urandom};
         start = poke && (out_valid || done) && (cyc % 2 == 0);
         tick();
         cyc++;
      end
      start = 1'b0;
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic check_frame(input logic [47:0] p);
      check("n_words", q_data.size(), NW);
      check("n_done", n_done, 1);
      for (int k = 0; k < NW && k < q_data.size(); k++) begin
         check($sformatf("data%0d", k), q_data[k], exp_word(p, k/2, k%2));
         check($sformatf("row%0d", k), q_row[k], k/2);
         check($sformatf("last%0d", k), q_last[k], k == NW-1);
      end
   endtask

   initial begin
      logic [47:0] p;
      reset = 1'b1;
      start = 1'b0;
      sel_prev = 1'b0;
      alive_flat = '0;
      alive_prev_flat = '0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", out_data, 0);
      check("rst_row", out_row, 0);
      check("rst_last", out_last, 0);
      tick();

      // basic frame, hand values for row words
      alive_flat = pattern_plane();
      run_frame(0, 0, 0, 0);
      check("done_cycle", done_cyc, NW);
      for (int k = 0; k < NW && k < q_data.size(); k++) begin
         if (k % 2 == 0)
            check($sformatf("hand_w0_%0d", k), q_data[k], 8'h5C ^ 8'(k/2));
         else
            check($sformatf("hand_w1_%0d", k), q_data[k], 8'h0A);
      end
      check_frame(pattern_plane());
      tick();

      // backpressure
      run_frame(0, 1, 0, 0);
      check_frame(pattern_plane());
      tick();

      // previous plane, padding
      alive_flat = '0;
      alive_prev_flat = '1;
      run_frame(1, 0, 0, 0);
      for (int k = 0; k < NW && k < q_data.size(); k++)
         check($sformatf("prev%0d", k), q_data[k],
               (k % 2 == 0) ? 8'hFF : 8'h0F);
      check("prev_n_words", q_data.size(), NW);
      tick();

      // snapshot isolation, with start pokes and stalls
      p = 48'h1234_5678_9ABC;
      alive_flat = p;
      run_frame(0, 1, 1, 1);
      check_frame(p);
      tick();

      // reset mid-frame after third handshake
      alive_flat = pattern_plane();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      out_ready = 1'b0;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      tick();
      check("mid_rst_done2", done, 0);
      check("mid_rst_valid2", out_valid, 0);
      run_frame(0, 0, 0, 0);
      check_frame(pattern_plane());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/life_array_reader.md
# life_array_reader

Readback engine for the Life cell array: on request it snapshots the current (or previous) generation of every cell into an internal frame buffer, then streams the frame out row by row as fixed-width words over a valid/ready interface. It sits beside the cell array, opposite the scan-in load path (`write`/`val`), and feeds the display/host side. Because of the snapshot, the array keeps evolving during readback.

## Interface
Parameters:
- ROWS, 8, array rows (≥1)
- COLS, 8, array columns (≥1)
- WORD_W, 8, output word width (≥1)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request one frame readback; sampled only in IDLE
- sel_prev  in  1  0: read `alive` plane, 1: read `alive_prev` plane; sampled with start
- alive_flat  in  ROWS*COLS  current states, bit r*COLS+c = cell (r,c)
- alive_prev_flat  in  ROWS*COLS  previous states, same packing
- out_ready  in  1  sink accepts word
- out_valid  out  1  word available
- out_data  out  WORD_W  packed cell bits
- out_row  out  max(1,$clog2(ROWS))  row index of current word
- out_last  out  1  final word of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after final handshake

## Operation
- WPR (words per row) = ceil(COLS/WORD_W); frame = ROWS*WPR words.
- States: IDLE, SEND, DONE.
- IDLE: busy=0, out_valid=0. start=1 → load snapshot from plane chosen by sel_prev, clear row/word counters, go SEND.
- SEND: out_valid=1. out_data word w of row r: bit i = snapshot cell (r, w*WORD_W+i) for w*WORD_W+i < COLS, else 0. Column 0 in LSB.
- Handshake when out_valid & out_ready. On handshake: word++; if word==WPR-1 then word=0, row++. Handshake on last word (row==ROWS-1, word==WPR-1) → DONE.
- out_last = 1 exactly when presenting the last word of the frame.
- DONE: done=1, busy=0, out_valid=0 for one cycle, then IDLE.
- start during SEND/DONE ignored (no queuing); sel_prev ignored outside IDLE.
- Snapshot not updated during SEND; alive_flat changes have no effect on frame in progress.
- Counters never wrap past frame end; out_row holds ROWS-1 until DONE.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_row 0, out_last 0, busy 0, done 0, counters 0; snapshot contents don't-care.
- start sampled at edge k → busy and out_valid high from cycle k+1, first word (row 0, word 0) presented then.
- With out_ready held high: one word per cycle; frame of N words occupies cycles k+1..k+N; done high in cycle k+N+1; start may be accepted at edge ending that DONE cycle? No: start accepted only in IDLE, earliest cycle k+N+2.
- out_data, out_row, out_last stable while out_valid=1 and out_ready=0; out_valid never drops without handshake except on reset.
- out_ready ignored when out_valid=0.
- Reset mid-frame: next cycle IDLE, out_valid 0, no done pulse; partial frame abandoned.
- All outputs registered; no combinational path from out_ready to out_valid/out_data.

## Structure
- Shared package life_pkg: state enum (IDLE, SEND, DONE), width helper functions (row counter width, WPR computation).
- One sub-module: life_word_select — combinational; given the snapshot, row and word index, returns the zero-padded WORD_W slice. Top holds FSM, counters, snapshot register and output registers.

## Test plan
- ROWS=4, COLS=12, WORD_W=8, ready always 1, alive_flat row r = 12'hA5C ^ r: start → 8 words; row 0 words 0x5C, 0x0A; out_last only on 8th; done one cycle after.
- Backpressure: out_ready toggled 1,0,0,1,… → every word delivered once, in order, stable across stall cycles; no duplicates or drops.
- sel_prev=1 with alive_prev_flat all ones, alive_flat zero → every word 0xFF for word 0, 0x0F for word 1 (padding zero).
- Snapshot isolation: alter alive_flat every cycle during SEND → output matches value present at start edge.
- start pulsed during SEND and DONE → ignored; exactly one frame, one done pulse.
- reset asserted after 3rd handshake → out_valid/busy 0 next cycle, no done; subsequent start yields full frame from word 0.
